pl_phy_msg_if: RTL and testbench

Protocol-layer message interface sitting directly above the PD PHY, on the opposite side of the `pl2phy_*` / `phy2pl_*` handshake. TX path: holds one outgoing message (≤30 bytes) in a local buffer, requests transmission, streams bytes on the PHY's per-byte handshake and reports the outcome. RX path: captures received bytes into a second buffer and presents a completed message (type, length, status) to the policy engine.

---
 rtl/pl_phy_msg_if.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pl_phy_msg_if.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_phy_msg_if.sv
// pl_phy_msg_if: protocol-layer message interface above the PD PHY.
//   TX path : 32x8 message buffer written by the policy engine, a five-state
//             FSM (IDLE/REQ/BYTE/WAIT/FIN) that requests a packet, streams the
//             payload on the PHY's per-byte handshake and reports tx_done/tx_ok.
//             A watchdog aborts the transfer after TX_TIMEOUT cycles without
//             PHY progress.
//   RX path : IDLE/ACTIVE FSM capturing PHY bytes into a second 32x8 buffer
//             (30 bytes kept, overflow flagged) and reporting type/len/status.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   tx_wr_*                       TX buffer write port (ignored while tx_busy)
//   tx_start/tx_type/tx_len       send request; tx_busy/tx_done/tx_ok outcome
//   bist_en, rx_sel, soft_reset   registered through to the PHY controls
//   rx_rd_addr/rx_rd_data         combinational RX buffer read
//   rx_valid/rx_type/rx_len/rx_status/rx_overflow  received message report
//   pl2phy_* / phy2pl_*           PHY-side handshake signals
//   dbg_tx_state, dbg_rx_state    current FSM states
// Handshake: a payload byte is transferred on every cycle where
//   pl2phy_tx_payload_en and phy2pl_tx_payload_done are both high; the next
//   byte is presented on the following cycle and payload_en stays high until
//   the last byte is acknowledged.
module pl_phy_msg_if #(
  parameter int TX_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_wr_en,
  input  logic [4:0] tx_wr_addr,
  input  logic [7:0] tx_wr_data,
  input  logic       tx_start,
  input  logic [2:0] tx_type,
  input  logic [4:0] tx_len,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ok,
  input  logic       bist_en,
  input  logic       rx_sel,
  input  logic       soft_reset,
  input  logic [4:0] rx_rd_addr,
  output logic [7:0] rx_rd_data,
  output logic       rx_valid,
  output logic [2:0] rx_type,
  output logic [4:0] rx_len,
  output logic [1:0] rx_status,
  output logic       rx_overflow,
  output logic       pl2phy_tx_packet_en,
  output logic [2:0] pl2phy_tx_packet_type,
  input  logic       phy2pl_tx_packet_done,
  input  logic       phy2pl_tx_packet_result,
  output logic       pl2phy_tx_payload_en,
  output logic [7:0] pl2phy_tx_payload,
  output logic       pl2phy_tx_payload_last,
  input  logic       phy2pl_tx_payload_done,
  input  logic       phy2pl_rx_packet_en,
  input  logic [2:0] phy2pl_rx_packet_type,
  input  logic       phy2pl_rx_payload_en,
  input  logic [7:0] phy2pl_rx_payload,
  input  logic       phy2pl_rx_packet_done,
  input  logic [1:0] phy2pl_rx_packet_result,
  output logic       pl2phy_rx_packet_select,
  output logic       pl2phy_tx_bist_carrier_mode,
  output logic       pl2phy_reset_req,
  output logic [2:0] dbg_tx_state,
  output logic       dbg_rx_state
);

  localparam int WDW = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_REQ, TX_BYTE, TX_WAIT, TX_FIN} tx_state_t;
  typedef enum logic {RX_IDLE, RX_ACTIVE} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [7:0]     tx_buf [32];
  logic [7:0]     rx_buf [32];
  logic [2:0]     type_q;
  logic [4:0]     len_q;
  logic [4:0]     idx;
  logic [WDW-1:0] wd;
  logic           ok_q;
  logic [2:0]     rx_type_q;
  logic [4:0]     rx_cnt;
  logic           rx_ovf_q;

  logic tx_active, is_ctrl, start_ctrl, bad_len, last_byte, wd_exp;
  logic rx_wr, rx_drop, rx_fin;

  assign tx_active  = (tx_state == TX_REQ) || (tx_state == TX_BYTE) || (tx_state == TX_WAIT);
  assign is_ctrl    = (type_q == 3'd5) || (type_q == 3'd6);
  assign start_ctrl = (tx_type == 3'd5) || (tx_type == 3'd6);
  assign bad_len    = !start_ctrl && ((tx_len < 5'd2) || (tx_len > 5'd30));
  assign last_byte  = (idx == len_q - 5'd1);
  // A byte acknowledged on the expiry cycle counts as progress.
  assign wd_exp     = (wd == WDW'(TX_TIMEOUT - 1)) && !phy2pl_tx_payload_done;

  // Control copies towards the PHY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl2phy_tx_bist_carrier_mode <= 1'b0;
      pl2phy_rx_packet_select     <= 1'b0;
      pl2phy_reset_req            <= 1'b0;
    end else begin
      pl2phy_tx_bist_carrier_mode <= bist_en;
      pl2phy_rx_packet_select     <= rx_sel;
      pl2phy_reset_req            <= soft_reset;
    end
  end

  // TX buffer: no reset, writes blocked while a message is owned by the FSM.
  always_ff @(posedge clk) begin
    if (tx_wr_en && !tx_busy) tx_buf[tx_wr_addr] <= tx_wr_data;
  end

  // TX FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX FSM: next state. The PHY soft reset overrides everything.
  always_comb begin
    tx_next = tx_state;
    if (pl2phy_reset_req) begin
      tx_next = TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_start) tx_next = bad_len ? TX_FIN : TX_REQ;
        TX_REQ:  if (wd_exp) tx_next = TX_FIN;
                 else        tx_next = is_ctrl ? TX_WAIT : TX_BYTE;
        TX_BYTE: if (wd_exp || phy2pl_tx_packet_done)              tx_next = TX_FIN;
                 else if (phy2pl_tx_payload_done && last_byte)     tx_next = TX_WAIT;
        TX_WAIT: if (phy2pl_tx_packet_done || wd_exp) tx_next = TX_FIN;
        TX_FIN:  tx_next = TX_IDLE;
        default: tx_next = TX_IDLE;
      endcase
    end
  end

  // TX FSM: PHY-facing outputs decoded from state.
  always_comb begin
    pl2phy_tx_packet_en    = 1'b0;
    pl2phy_tx_packet_type  = 3'd0;
    pl2phy_tx_payload_en   = 1'b0;
    pl2phy_tx_payload      = 8'd0;
    pl2phy_tx_payload_last = 1'b0;
    if (tx_state == TX_REQ) begin
      pl2phy_tx_packet_en   = 1'b1;
      pl2phy_tx_packet_type = type_q;
    end
    if (tx_state == TX_BYTE) begin
      pl2phy_tx_payload_en   = 1'b1;
      pl2phy_tx_payload      = tx_buf[idx];
      pl2phy_tx_payload_last = last_byte;
    end
  end

  // TX datapath: latched request, byte index, watchdog, PHY result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q <= 3'd0;
      len_q  <= 5'd0;
      idx    <= 5'd0;
      wd     <= '0;
      ok_q   <= 1'b0;
    end else if (pl2phy_reset_req) begin
      idx  <= 5'd0;
      wd   <= '0;
      ok_q <= 1'b0;
    end else begin
      if (tx_state == TX_IDLE && tx_start) begin
        type_q <= tx_type;
        len_q  <= tx_len;
        ok_q   <= 1'b0;
      end
      if (tx_active) wd <= phy2pl_tx_payload_done ? '0 : wd + WDW'(1);
      else           wd <= '0;
      if (tx_state == TX_REQ) idx <= 5'd0;
      else if (tx_state == TX_BYTE && phy2pl_tx_payload_done && !last_byte) idx <= idx + 5'd1;
      if (tx_state == TX_WAIT && phy2pl_tx_packet_done) ok_q <= phy2pl_tx_packet_result;
    end
  end

  // TX status outputs are registered: tx_done follows FIN by one cycle, or
  // follows a soft reset that interrupted an in-flight transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_ok   <= 1'b0;
    end else begin
      tx_done <= (tx_state == TX_FIN) || (pl2phy_reset_req && tx_active);
      tx_ok   <= (tx_state == TX_FIN) && ok_q;
      if ((tx_state == TX_FIN) || pl2phy_reset_req) tx_busy <= 1'b0;
      else if (tx_state == TX_IDLE && tx_start)     tx_busy <= 1'b1;
    end
  end

  // RX path. A new packet_en restarts capture from any state.
  assign rx_wr   = (rx_state == RX_ACTIVE) && !pl2phy_reset_req && !phy2pl_rx_packet_en &&
                   phy2pl_rx_payload_en && (rx_cnt < 5'd30);
  assign rx_drop = (rx_state == RX_ACTIVE) && !pl2phy_reset_req && !phy2pl_rx_packet_en &&
                   phy2pl_rx_payload_en && (rx_cnt >= 5'd30);
  assign rx_fin  = (rx_state == RX_ACTIVE) && !pl2phy_reset_req && !phy2pl_rx_packet_en &&
                   phy2pl_rx_packet_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (pl2phy_reset_req)         rx_next = RX_IDLE;
    else if (phy2pl_rx_packet_en) rx_next = RX_ACTIVE;
    else if (rx_fin)              rx_next = RX_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_buf[rx_cnt] <= phy2pl_rx_payload;
  end

  // A byte arriving with packet_done is stored and counted before reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_type_q   <= 3'd0;
      rx_cnt      <= 5'd0;
      rx_ovf_q    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_type     <= 3'd0;
      rx_len      <= 5'd0;
      rx_status   <= 2'd0;
      rx_overflow <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (pl2phy_reset_req) begin
        rx_cnt   <= 5'd0;
        rx_ovf_q <= 1'b0;
      end else if (phy2pl_rx_packet_en) begin
        rx_type_q <= phy2pl_rx_packet_type;
        rx_cnt    <= 5'd0;
        rx_ovf_q  <= 1'b0;
      end else begin
        if (rx_wr)   rx_cnt   <= rx_cnt + 5'd1;
        if (rx_drop) rx_ovf_q <= 1'b1;
        if (rx_fin) begin
          rx_valid    <= 1'b1;
          rx_type     <= rx_type_q;
          rx_len      <= rx_wr ? rx_cnt + 5'd1 : rx_cnt;
          rx_status   <= phy2pl_rx_packet_result;
          rx_overflow <= rx_ovf_q || rx_drop;
        end
      end
    end
  end

  assign rx_rd_data   = rx_buf[rx_rd_addr];
  assign dbg_tx_state = tx_state;
  assign dbg_rx_state = rx_state;

endmodule

// File: tb/tb_pl_phy_msg_if.sv
// Testbench for pl_phy_msg_if: directed steps plus randomized TX/RX messages
// checked against a buffer/queue model of the message rules.
module tb_pl_phy_msg_if;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_wr_en, tx_start, bist_en, rx_sel, soft_reset;
  logic [4:0] tx_wr_addr, tx_len, rx_rd_addr;
  logic [7:0] tx_wr_data;
  logic [2:0] tx_type;
  logic       tx_busy, tx_done, tx_ok;
  logic [7:0] rx_rd_data;
  logic       rx_valid, rx_overflow;
  logic [2:0] rx_type;
  logic [4:0] rx_len;
  logic [1:0] rx_status;
  logic       pkt_en, pl_done, pl_res, pay_en, pay_last, pay_done;
  logic [2:0] pkt_type;
  logic [7:0] pay;
  logic       rxp_en, rxb_en, rxp_done;
  logic [2:0] rxp_type;
  logic [7:0] rxb;
  logic [1:0] rxp_res;
  logic       rx_select, bist_mode, reset_req;
  logic [2:0] dbg_tx_state;
  logic       dbg_rx_state;

  always #5 clk = ~clk;

  pl_phy_msg_if #(.TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr), .tx_wr_data(tx_wr_data),
    .tx_start(tx_start), .tx_type(tx_type), .tx_len(tx_len),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_ok(tx_ok),
    .bist_en(bist_en), .rx_sel(rx_sel), .soft_reset(soft_reset),
    .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data),
    .rx_valid(rx_valid), .rx_type(rx_type), .rx_len(rx_len),
    .rx_status(rx_status), .rx_overflow(rx_overflow),
    .pl2phy_tx_packet_en(pkt_en), .pl2phy_tx_packet_type(pkt_type),
    .phy2pl_tx_packet_done(pl_done), .phy2pl_tx_packet_result(pl_res),
    .pl2phy_tx_payload_en(pay_en), .pl2phy_tx_payload(pay),
    .pl2phy_tx_payload_last(pay_last), .phy2pl_tx_payload_done(pay_done),
    .phy2pl_rx_packet_en(rxp_en), .phy2pl_rx_packet_type(rxp_type),
    .phy2pl_rx_payload_en(rxb_en), .phy2pl_rx_payload(rxb),
    .phy2pl_rx_packet_done(rxp_done), .phy2pl_rx_packet_result(rxp_res),
    .pl2phy_rx_packet_select(rx_select), .pl2phy_tx_bist_carrier_mode(bist_mode),
    .pl2phy_reset_req(reset_req),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_mem[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {tx_busy, tx_done, tx_ok, rx_valid, rx_type, rx_len, rx_status, rx_overflow,
            pkt_en, pkt_type, pay_en, pay, pay_last, rx_select, bist_mode, reset_req};
  endfunction

  task automatic write_tx(input logic [4:0] a, input logic [7:0] d, input bit taken);
    tx_wr_en = 1'b1; tx_wr_addr = a; tx_wr_data = d;
    step();
    tx_wr_en = 1'b0;
    if (taken) tx_mem[a] = d;
  endtask

  // Full transmit: the bench plays the PHY, acking each byte after d cycles.
  task automatic run_tx(input logic [2:0] typ, input logic [4:0] len, input logic res, input int fixed_d);
    int got, wait_cnt, d, cyc;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(tx_mem[i]);
    tx_type = typ; tx_len = len; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check("tx_busy_at_T1", tx_busy, 1);
    check("pkt_en_at_T1", pkt_en, 1);
    check("pkt_type", pkt_type, typ);
    step();
    check("pkt_en_single", pkt_en, 0);
    if (typ == 3'd5 || typ == 3'd6) begin
      for (int i = 0; i < 3; i++) begin
        check("ctrl_no_payload", pay_en, 0);
        step();
      end
      write_tx(5'd0, ~tx_mem[0], 1'b0);
      check("ctrl_no_payload_wr", pay_en, 0);
    end else begin
      check("first_byte_T2", pay_en, 1);
      got = 0; wait_cnt = 0; cyc = 0;
      d = (fixed_d < 0) ? int'($urandom_range(0, 3)) : fixed_d;
      while (got < int'(len) && cyc < 2000) begin
        if (pay_en) begin
          if (wait_cnt == d) begin
            check("payload_byte", pay, exp_q[got]);
            check("payload_last", pay_last, (got == int'(len) - 1));
            pay_done = 1'b1;
            got++;
            wait_cnt = 0;
            d = (fixed_d < 0) ? int'($urandom_range(0, 3)) : fixed_d;
          end else begin
            wait_cnt++;
          end
        end
        step();
        pay_done = 1'b0;
        cyc++;
      end
      check("all_bytes_acked", got, len);
      check("payload_en_low_after_last", pay_en, 0);
    end
    repeat ($urandom_range(0, 3)) step();
    check("busy_before_done", tx_busy, 1);
    pl_done = 1'b1; pl_res = res;
    step();
    pl_done = 1'b0; pl_res = 1'b0;
    check("tx_done_not_at_D1", tx_done, 0);
    step();
    check("tx_done_at_D2", tx_done, 1);
    check("tx_ok", tx_ok, res);
    check("busy_clear_at_D2", tx_busy, 0);
    step();
    check("tx_done_pulse", tx_done, 0);
  endtask

  // Receive n bytes; same=1 puts packet_done on the last byte's cycle.
  task automatic rx_msg(input logic [2:0] typ, input int n, input logic [1:0] res, input bit same);
    logic [7:0] b;
    int vseen;
    int exp_len;
    exp_q.delete();
    vseen = 0;
    rxp_en = 1'b1; rxp_type = typ;
    step();
    rxp_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) begin
        step();
        if (rx_valid) vseen++;
      end
      b = 8'($urandom);
      if (i < 30) exp_q.push_back(b);
      rxb_en = 1'b1; rxb = b;
      if (same && i == n - 1) begin
        rxp_done = 1'b1; rxp_res = res;
      end
      step();
      rxb_en = 1'b0;
      if (!(same && i == n - 1) && rx_valid) vseen++;
    end
    if (!same) begin
      rxp_done = 1'b1; rxp_res = res;
      step();
    end
    rxp_done = 1'b0;
    exp_len = (n > 30) ? 30 : n;
    check("rx_no_early_valid", vseen, 0);
    check("rx_valid", rx_valid, 1);
    check("rx_type", rx_type, typ);
    check("rx_len", rx_len, exp_len);
    check("rx_status", rx_status, res);
    check("rx_overflow", rx_overflow, (n > 30));
    for (int i = 0; i < exp_q.size(); i++) begin
      rx_rd_addr = 5'(i);
      #1;
      check("rx_buf_byte", rx_rd_data, exp_q[i]);
    end
    step();
    check("rx_valid_pulse", rx_valid, 0);
    check("rx_len_held", rx_len, exp_len);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pe_cnt, cyc, rr_cnt, len;
    logic seen_done, ok_v;
    logic [4:0] bad_lens[2];

    rst_n = 1'b0;
    tx_wr_en = 0; tx_wr_addr = 0; tx_wr_data = 0; tx_start = 0; tx_type = 0; tx_len = 0;
    bist_en = 0; rx_sel = 0; soft_reset = 0; rx_rd_addr = 0;
    pl_done = 0; pl_res = 0; pay_done = 0;
    rxp_en = 0; rxp_type = 0; rxb_en = 0; rxb = 0; rxp_done = 0; rxp_res = 0;
    for (int i = 0; i < 32; i++) tx_mem[i] = 8'h00;

    // Reset state.
    repeat (3) step();
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    step();
    check("post_reset_outputs", all_outs(), 0);

    // Registered control copies.
    bist_en = 1'b1; rx_sel = 1'b1;
    step();
    check("bist_copy", bist_mode, 1);
    check("rx_sel_copy", rx_select, 1);
    bist_en = 1'b0; rx_sel = 1'b0;
    step();
    check("bist_copy_low", bist_mode, 0);

    // Directed six-byte SOP message.
    for (int i = 0; i < 6; i++) write_tx(5'(i), 8'h41 + 8'(i), 1'b1);
    run_tx(3'd0, 5'd6, 1'b1, 3);

    // Hard Reset: no payload, PHY reports failure.
    run_tx(3'd5, 5'd2, 1'b0, 0);

    // Out-of-range lengths end immediately without a packet request.
    bad_lens[0] = 5'd1; bad_lens[1] = 5'd31;
    for (int k = 0; k < 2; k++) begin
      tx_type = 3'd0; tx_len = bad_lens[k]; tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      check("badlen_busy", tx_busy, 1);
      check("badlen_no_pkt", pkt_en, 0);
      step();
      check("badlen_done", tx_done, 1);
      check("badlen_ok", tx_ok, 0);
      step();
    end

    // Watchdog: PHY never acknowledges the first byte.
    tx_type = 3'd0; tx_len = 5'd8; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    step();
    pe_cnt = 0; cyc = 0;
    while (!tx_done && cyc < 100) begin
      if (pay_en) pe_cnt++;
      step();
      cyc++;
    end
    check("timeout_done", tx_done, 1);
    check("timeout_ok", tx_ok, 0);
    check("timeout_payload_low", pay_en, 0);
    check("timeout_not_early", (pe_cnt >= TO - 2), 1);
    check("timeout_not_late", (pe_cnt <= TO), 1);
    step();

    // Randomized messages.
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(2, 30);
      for (int i = 0; i < len; i++) write_tx(5'(i), 8'($urandom), 1'b1);
      run_tx(3'($urandom_range(0, 4)), 5'(len), 1'($urandom), -1);
    end

    // Soft reset while streaming bytes.
    tx_type = 3'd0; tx_len = 5'd10; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    step();
    step();
    check("sr_in_byte", pay_en, 1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    check("sr_reset_req", reset_req, 1);
    rr_cnt = 1; seen_done = 1'b0; ok_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (reset_req) rr_cnt++;
      if (tx_done) begin
        seen_done = 1'b1;
        ok_v = tx_ok;
      end
    end
    check("sr_req_one_cycle", rr_cnt, 1);
    check("sr_tx_done", seen_done, 1);
    check("sr_tx_ok", ok_v, 0);
    check("sr_busy_clear", tx_busy, 0);
    check("sr_payload_low", pay_en, 0);
    len = $urandom_range(2, 30);
    run_tx(3'd1, 5'(len), 1'b1, -1);

    // RX directed, overflow, restart, ignored done, randomized.
    rxp_done = 1'b1; rxp_res = 2'b11;
    step();
    rxp_done = 1'b0;
    check("rx_done_idle_ignored", rx_valid, 0);
    rx_msg(3'd1, 4, 2'b01, 1'b0);
    rx_msg(3'd0, 33, 2'b00, 1'b0);
    rxp_en = 1'b1; rxp_type = 3'd2;
    step();
    rxp_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rxb_en = 1'b1; rxb = 8'hE0 + 8'(i);
      step();
    end
    rxb_en = 1'b0;
    check("restart_no_valid", rx_valid, 0);
    rx_msg(3'd3, 3, 2'b10, 1'b0);
    for (int r = 0; r < 4; r++)
      rx_msg(3'($urandom_range(0, 7)), $urandom_range(1, 34), 2'($urandom), 1'($urandom));

    // Asynchronous reset in the middle of a received message.
    bist_en = 1'b1;
    rxp_en = 1'b1; rxp_type = 3'd4;
    step();
    rxp_en = 1'b0;
    rxb_en = 1'b1; rxb = 8'h5A;
    step();
    step();
    rxb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    bist_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rxp_done = 1'b1; rxp_res = 2'b00;
    step();
    rxp_done = 1'b0;
    check("rx_dropped_after_reset", rx_valid, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
